// File: rtl/recorder_pkg.sv
// Shared definitions between the front-panel controller and the audio core:
// command codes, mode encodings, transport states and the packed event layout.
package recorder_pkg;

   localparam logic [3:0] REC_NONE   = 4'd0;
   localparam logic [3:0] REC_PLAY   = 4'd1;
   localparam logic [3:0] REC_PAUSE  = 4'd2;
   localparam logic [3:0] REC_STOP   = 4'd3;
   localparam logic [3:0] REC_RECORD = 4'd4;

   localparam logic [1:0] REC_NORMAL = 2'd0;
   localparam logic [1:0] REC_SLOW   = 2'd1;
   localparam logic [1:0] REC_FAST   = 2'd2;

   localparam logic [3:0] SPEED_MIN = 4'd1;
   localparam logic [3:0] SPEED_MAX = 4'd8;

   localparam int EV_CODE_LSB     = 12;
   localparam int EV_MODE_LSB     = 10;
   localparam int EV_SPEED_LSB    = 6;
   localparam int EV_INTERPOL_BIT = 5;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_PLAYING     = 3'd1,
      ST_PLAY_PAUSED = 3'd2,
      ST_RECORDING   = 3'd3,
      ST_REC_PAUSED  = 3'd4
   } rec_state_e;

   // The reserved switch setting 3 falls back to normal playback.
   function automatic logic [1:0] map_mode(input logic [1:0] sw);
      case (sw)
         REC_SLOW: map_mode = REC_SLOW;
         REC_FAST: map_mode = REC_FAST;
         default:  map_mode = REC_NORMAL;
      endcase
   endfunction

   function automatic logic [15:0] pack_event(input logic [3:0] code, input logic [1:0] mode,
                                              input logic [3:0] speed, input logic interpol);
      pack_event = 16'd0;
      pack_event[EV_CODE_LSB +: 4]   = code;
      pack_event[EV_MODE_LSB +: 2]   = mode;
      pack_event[EV_SPEED_LSB +: 4]  = speed;
      pack_event[EV_INTERPOL_BIT]    = interpol;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-FF synchronizer, stability-counter debounce and a
// one-cycle pulse on each accepted press (debounced high-to-low).
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key_n,
   output logic o_press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d, level_dly_q, press_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // Level flips on the Nth consecutive disagreeing sample; any agreement restarts.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         level_q     <= 1'b1;
         level_dly_q <= 1'b1;
         cnt_q       <= '0;
         press_q     <= 1'b0;
      end else begin
         sync1_q     <= i_key_n;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         cnt_q       <= cnt_d;
         press_q     <= level_dly_q & ~level_q;
      end
   end

   assign o_press = press_q;

endmodule

// File: rtl/recorder_event_ctrl.sv
// Front-panel controller: debounced keys drive a shadow transport state and
// produce the packed 16-bit control event consumed by the audio core.
module recorder_event_ctrl
   import recorder_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CODE_HOLD       = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_key_play_pause,
   input  logic        i_key_stop,
   input  logic        i_key_record,
   input  logic        i_key_speed_up,
   input  logic        i_key_speed_down,
   input  logic [1:0]  i_sw_mode,
   input  logic        i_sw_interpol,
   input  logic        i_stop_signal,
   output logic [15:0] o_event,
   output logic [2:0]  o_state,
   output logic [3:0]  o_speed
);

   localparam int K_PP = 0, K_STOP = 1, K_REC = 2, K_UP = 3, K_DN = 4;
   localparam int HW = $clog2(CODE_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(CODE_HOLD);

   logic [4:0]  keys_n_s, press_s;
   logic [1:0]  mode_s1_q, mode_s2_q;
   logic        int_s1_q, int_s2_q;
   rec_state_e  state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [3:0]  speed_q, speed_d, code_new_s, code_d;
   logic [15:0] event_q, event_d;
   logic        stop_req_s;

   assign keys_n_s = {i_key_speed_down, i_key_speed_up, i_key_record, i_key_stop, i_key_play_pause};

   for (genvar g = 0; g < 5; g++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_key_n (keys_n_s[g]),
         .o_press (press_s[g])
      );
   end

   // Transport decision: one winner (stop > record > play_pause), only outside a hold window.
   always_comb begin
      state_d    = state_q;
      code_new_s = REC_NONE;
      stop_req_s = press_s[K_STOP] | ((state_q == ST_PLAYING) & i_stop_signal);
      if (hold_q == '0) begin
         if (stop_req_s) begin
            if (state_q != ST_IDLE) begin
               code_new_s = REC_STOP;
               state_d    = ST_IDLE;
            end else begin
               state_d = state_q;
            end
         end else if (press_s[K_REC]) begin
            if (state_q inside {ST_IDLE, ST_PLAY_PAUSED, ST_REC_PAUSED}) begin
               code_new_s = REC_RECORD;
               state_d    = ST_RECORDING;
            end else begin
               state_d = state_q;
            end
         end else if (press_s[K_PP]) begin
            case (state_q)
               ST_IDLE, ST_PLAY_PAUSED, ST_REC_PAUSED: begin
                  code_new_s = REC_PLAY;
                  state_d    = ST_PLAYING;
               end
               ST_PLAYING: begin
                  code_new_s = REC_PAUSE;
                  state_d    = ST_PLAY_PAUSED;
               end
               ST_RECORDING: begin
                  code_new_s = REC_PAUSE;
                  state_d    = ST_REC_PAUSED;
               end
               default: state_d = ST_IDLE;
            endcase
         end else begin
            state_d = state_q;
         end
      end else begin
         state_d = state_q;
      end
   end

   // Code stays visible while the hold counter runs down, then reverts to NONE.
   always_comb begin
      hold_d = '0;
      code_d = REC_NONE;
      if (code_new_s != REC_NONE) begin
         hold_d = HOLD_LOAD;
         code_d = code_new_s;
      end else if (hold_q > HW'(1)) begin
         hold_d = hold_q - HW'(1);
         code_d = event_q[EV_CODE_LSB +: 4];
      end else begin
         hold_d = '0;
         code_d = REC_NONE;
      end
   end

   // Speed factor, saturating 1..8; pressing both keys together cancels.
   always_comb begin
      speed_d = speed_q;
      if (press_s[K_UP] && !press_s[K_DN]) begin
         speed_d = (speed_q != SPEED_MAX) ? speed_q + 4'd1 : speed_q;
      end else if (press_s[K_DN] && !press_s[K_UP]) begin
         speed_d = (speed_q != SPEED_MIN) ? speed_q - 4'd1 : speed_q;
      end else begin
         speed_d = speed_q;
      end
      event_d = pack_event(code_d, map_mode(mode_s2_q), speed_d, int_s2_q);
   end

   // Registered state, outputs and switch synchronizers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_IDLE;
         hold_q    <= '0;
         speed_q   <= SPEED_MIN;
         event_q   <= pack_event(REC_NONE, REC_NORMAL, SPEED_MIN, 1'b0);
         mode_s1_q <= 2'd0;
         mode_s2_q <= 2'd0;
         int_s1_q  <= 1'b0;
         int_s2_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         speed_q   <= speed_d;
         event_q   <= event_d;
         mode_s1_q <= i_sw_mode;
         mode_s2_q <= mode_s1_q;
         int_s1_q  <= i_sw_interpol;
         int_s2_q  <= int_s1_q;
      end
   end

   assign o_event = event_q;
   assign o_state = state_q;
   assign o_speed = speed_q;

endmodule

// File: tb/tb_recorder_event_ctrl.sv
// Self-checking bench for recorder_event_ctrl: directed vector table, hand
// sequences for latency/bounce/auto-stop/reset, and a random run against a model.
module tb_recorder_event_ctrl;

   localparam int DEB  = 4;
   localparam int HOLD = 4;
   localparam int MAXC = 8192;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  key_n;   // bit0 play_pause, 1 stop, 2 record, 3 speed_up, 4 speed_down
   logic [1:0]  sw_mode;
   logic        sw_int;
   logic        stop_sig;
   logic [15:0] o_event;
   logic [2:0]  o_state;
   logic [3:0]  o_speed;

   always #5 clk = ~clk;

   recorder_event_ctrl #(.DEBOUNCE_CYCLES(DEB), .CODE_HOLD(HOLD)) dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_key_play_pause (key_n[0]),
      .i_key_stop       (key_n[1]),
      .i_key_record     (key_n[2]),
      .i_key_speed_up   (key_n[3]),
      .i_key_speed_down (key_n[4]),
      .i_sw_mode        (sw_mode),
      .i_sw_interpol    (sw_int),
      .i_stop_signal    (stop_sig),
      .o_event          (o_event),
      .o_state          (o_state),
      .o_speed          (o_speed)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: per-cycle histories of raw inputs and debounced levels.
   logic       raw_h [5][MAXC];
   logic       lvl_h [5][MAXC];
   logic [1:0] mode_h [MAXC];
   logic       int_h [MAXC];
   int         run [5];
   int         cyc;
   int         m_state, m_code, m_issue, m_speed;
   logic [15:0] m_event;

   typedef struct {
      logic [4:0] press;
      logic [1:0] mode;
      logic       interp;
      int         exp_code;
      int         exp_state;
      int         exp_speed;
      int         exp_mode;
   } vec_t;
   vec_t tbl [22];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 5; k++) begin
         for (int c = 0; c < 4; c++) begin
            raw_h[k][c] = 1'b1;
            lvl_h[k][c] = 1'b1;
         end
         run[k] = 0;
      end
      for (int c = 0; c < 4; c++) begin
         mode_h[c] = 2'd0;
         int_h[c]  = 1'b0;
      end
      cyc = 3; m_state = 0; m_code = 0; m_issue = -100; m_speed = 1;
   endfunction

   // Transport table: key 0 play_pause, 1 stop, 2 record; states 0..4 in listed order.
   function automatic void trans(input int st, input int key, output int nst, output int code);
      nst = st; code = 0;
      if (key == 1 && st != 0) begin nst = 0; code = 3; end
      else if (key == 2 && (st == 0 || st == 2 || st == 4)) begin nst = 3; code = 4; end
      else if (key == 0 && (st == 0 || st == 2 || st == 4)) begin nst = 1; code = 1; end
      else if (key == 0 && st == 1) begin nst = 2; code = 2; end
      else if (key == 0 && st == 3) begin nst = 4; code = 2; end
   endfunction

   function automatic void model_edge(input logic ss);
      int t, key, nst, code;
      logic press [5];
      logic [3:0] c4, s4;
      logic [1:0] md;
      t = cyc;
      for (int k = 0; k < 5; k++) begin
         press[k] = lvl_h[k][t-2] & ~lvl_h[k][t-1];
         if (raw_h[k][t-2] != lvl_h[k][t]) begin
            run[k]++;
            lvl_h[k][t+1] = (run[k] >= DEB) ? raw_h[k][t-2] : lvl_h[k][t];
            if (run[k] >= DEB) run[k] = 0;
         end else begin
            run[k] = 0;
            lvl_h[k][t+1] = lvl_h[k][t];
         end
      end
      if (t >= m_issue + HOLD) begin
         key = -1;
         if (press[1] || (m_state == 1 && ss)) key = 1;
         else if (press[2]) key = 2;
         else if (press[0]) key = 0;
         if (key >= 0) begin
            trans(m_state, key, nst, code);
            if (code != 0) begin m_state = nst; m_code = code; m_issue = t + 1; end
         end
      end
      if (press[3] && !press[4]) m_speed = (m_speed < 8) ? m_speed + 1 : 8;
      else if (press[4] && !press[3]) m_speed = (m_speed > 1) ? m_speed - 1 : 1;
      c4 = (t + 1 < m_issue + HOLD) ? m_code[3:0] : 4'd0;
      md = (mode_h[t-2] == 2'd3) ? 2'd0 : mode_h[t-2];
      s4 = m_speed[3:0];
      m_event = {c4, md, s4, int_h[t-2], 5'd0};
   endfunction

   task automatic step(input logic [4:0] kn, input logic [1:0] md, input logic it, input logic ss);
      if (cyc >= MAXC - 2) begin
         $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 2);
         $fatal(1, "history overflow");
      end
      key_n = kn; sw_mode = md; sw_int = it; stop_sig = ss;
      for (int k = 0; k < 5; k++) raw_h[k][cyc] = kn[k];
      mode_h[cyc] = md; int_h[cyc] = it;
      @(posedge clk); #1;
      model_edge(ss);
      check("model_event", o_event, m_event);
      check("model_state", o_state, m_state);
      check("model_speed", o_speed, m_speed);
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; key_n = 5'h1F; sw_mode = 2'd0; sw_int = 1'b0; stop_sig = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Press mask for 12 cycles, release for 12; returns the last non-zero code seen.
   task automatic press_cycle(input logic [4:0] mask, input logic [1:0] md, input logic it, output int seen);
      seen = 0;
      for (int i = 0; i < 24; i++) begin
         step((i < 12) ? ~mask : 5'h1F, md, it, 1'b0);
         if (o_event[15:12] != 4'd0) seen = int'(o_event[15:12]);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int seen, cnt;
      logic [4:0] rk;
      int dur [5];

      tbl[0]  = '{5'b00001, 2'd0, 1'b0, 1, 1, 1, 0};
      tbl[1]  = '{5'b00001, 2'd0, 1'b0, 2, 2, 1, 0};
      tbl[2]  = '{5'b00001, 2'd0, 1'b0, 1, 1, 1, 0};
      tbl[3]  = '{5'b00001, 2'd0, 1'b0, 2, 2, 1, 0};
      tbl[4]  = '{5'b00110, 2'd0, 1'b0, 3, 0, 1, 0};
      tbl[5]  = '{5'b00010, 2'd0, 1'b0, 0, 0, 1, 0};
      tbl[6]  = '{5'b00100, 2'd0, 1'b0, 4, 3, 1, 0};
      tbl[7]  = '{5'b00001, 2'd0, 1'b0, 2, 4, 1, 0};
      tbl[8]  = '{5'b00100, 2'd0, 1'b0, 4, 3, 1, 0};
      tbl[9]  = '{5'b00001, 2'd0, 1'b0, 2, 4, 1, 0};
      tbl[10] = '{5'b00001, 2'd0, 1'b0, 1, 1, 1, 0};
      tbl[11] = '{5'b00010, 2'd0, 1'b0, 3, 0, 1, 0};
      tbl[12] = '{5'b01000, 2'd0, 1'b0, 0, 0, 2, 0};
      tbl[13] = '{5'b11000, 2'd0, 1'b0, 0, 0, 2, 0};
      tbl[14] = '{5'b10000, 2'd0, 1'b0, 0, 0, 1, 0};
      tbl[15] = '{5'b10000, 2'd0, 1'b0, 0, 0, 1, 0};
      tbl[16] = '{5'b00001, 2'd3, 1'b0, 1, 1, 1, 0};
      tbl[17] = '{5'b00001, 2'd2, 1'b1, 2, 2, 1, 2};
      tbl[18] = '{5'b00010, 2'd1, 1'b0, 3, 0, 1, 1};
      tbl[19] = '{5'b00001, 2'd0, 1'b0, 1, 1, 1, 0};
      tbl[20] = '{5'b00100, 2'd0, 1'b0, 0, 1, 1, 0};
      tbl[21] = '{5'b00010, 2'd0, 1'b0, 3, 0, 1, 0};

      do_reset();
      check("reset_event", o_event, 16'h0040);
      check("reset_state", o_state, 0);
      check("reset_speed", o_speed, 1);

      for (int v = 0; v < 22; v++) begin
         press_cycle(tbl[v].press, tbl[v].mode, tbl[v].interp, seen);
         check($sformatf("tbl%0d_code", v), seen, tbl[v].exp_code);
         check($sformatf("tbl%0d_state", v), o_state, tbl[v].exp_state);
         check($sformatf("tbl%0d_speed", v), o_speed, tbl[v].exp_speed);
         check($sformatf("tbl%0d_mode", v), o_event[11:10], tbl[v].exp_mode);
         check($sformatf("tbl%0d_interp", v), o_event[5], int'(tbl[v].interp));
      end

      // Latency: code 1 visible in cycles 8..11 only.
      do_reset();
      for (int i = 0; i < 14; i++) begin
         step(5'h1E, 2'd0, 1'b0, 1'b0);
         check($sformatf("lat_code_c%0d", i + 1), o_event[15:12], (i + 1 >= 8 && i + 1 <= 11) ? 1 : 0);
         if (i + 1 == 8) check("lat_state", o_state, 1);
      end

      // Bounce: 2-cycle toggles never qualify; the final steady low gives one press.
      do_reset();
      cnt = 0;
      for (int i = 0; i < 52; i++) begin
         if (i < 20) step(((i / 2) % 2 == 0) ? 5'h1E : 5'h1F, 2'd0, 1'b0, 1'b0);
         else if (i < 40) step(5'h1E, 2'd0, 1'b0, 1'b0);
         else step(5'h1F, 2'd0, 1'b0, 1'b0);
         if (o_event[15:12] == 4'd1) cnt++;
      end
      check("bounce_play_cycles", cnt, 4);
      check("bounce_state", o_state, 1);

      // Auto-stop masked during the hold window, honoured after it.
      do_reset();
      for (int i = 0; i < 30; i++) begin
         step((i < 16) ? 5'h1E : 5'h1F, 2'd0, 1'b0, ((i >= 8 && i <= 11) || i == 14) ? 1'b1 : 1'b0);
         if (i == 11) check("as_masked_state", o_state, 1);
         if (i == 11) check("as_masked_code", o_event[15:12], 0);
         if (i == 13) check("as_pre_state", o_state, 1);
         if (i == 14) check("as_stop_code", o_event[15:12], 3);
         if (i == 14) check("as_stop_state", o_state, 0);
      end

      // Speed saturation both ways.
      do_reset();
      for (int i = 0; i < 10; i++) press_cycle(5'b01000, 2'd0, 1'b0, seen);
      check("speed_max", o_speed, 8);
      check("speed_max_event", o_event[9:6], 8);
      for (int i = 0; i < 10; i++) press_cycle(5'b10000, 2'd0, 1'b0, seen);
      check("speed_min", o_speed, 1);
      check("speed_min_event", o_event[9:6], 1);

      // Asynchronous reset inside a hold window clears the code at once.
      do_reset();
      for (int i = 0; i < 9; i++) step(5'h1E, 2'd0, 1'b0, 1'b0);
      check("mid_pre_code", o_event[15:12], 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_event", o_event, 16'h0040);
      check("mid_rst_state", o_state, 0);
      do_reset();

      // Random run against the model.
      rk = 5'h1F;
      for (int k = 0; k < 5; k++) dur[k] = 0;
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 5; k++) begin
            if (dur[k] == 0) begin
               rk[k] = 1'($urandom_range(0, 1));
               dur[k] = $urandom_range(1, 14);
            end
            dur[k]--;
         end
         if ($urandom_range(0, 49) == 0) sw_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) sw_int = 1'($urandom_range(0, 1));
         step(rk, sw_mode, sw_int, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/recorder_event_ctrl.md
# recorder_event_ctrl

Front-panel controller that sits directly upstream of the audio core. It turns the five DE2-115 pushbuttons and the mode/interpolation switches into the packed 16-bit control event the audio core consumes. It keeps a shadow transport state, so one key can toggle play and pause. It also converts the core's end-of-data flag into an automatic stop.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable synchronized samples required before a key level change is accepted (≥1).
- CODE_HOLD, 4: number of cycles a non-zero command code stays on o_event (≥3).

- i_clk  input  1  system clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_key_play_pause, i_key_stop, i_key_record, i_key_speed_up, i_key_speed_down  input  1 each  raw pushbuttons, active-low, asynchronous to i_clk
- i_sw_mode  input  2  0 normal, 1 slow, 2 fast, 3 treated as normal
- i_sw_interpol  input  1  interpolation enable for slow mode
- i_stop_signal  input  1  audio core end-of-data flag (level)
- o_event  output  16  [15:12] code, [11:10] mode, [9:6] speed, [5] interpol, [4:0] always 0
- o_state  output  3  shadow transport state
- o_speed  output  4  current speed factor, 1..8

## Operation
- Key path, one instance per key:
  - 2-FF synchronizer, then debounce.
  - The debounced level flips after the synchronized sample differs from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing sample restarts the count.
  - A press is a one-cycle pulse on a debounced high→low transition. Release generates nothing.
- Command codes: NONE=0, PLAY=1, PAUSE=2, STOP=3, RECORD=4.
- Shadow states: IDLE, PLAYING, PLAY_PAUSED, RECORDING, REC_PAUSED.
  - IDLE:
    - play_pause → PLAY, PLAYING
    - record → RECORD, RECORDING
  - PLAYING:
    - play_pause → PAUSE, PLAY_PAUSED
    - stop → STOP, IDLE
    - i_stop_signal=1 with hold counter 0 → STOP, IDLE
  - PLAY_PAUSED:
    - play_pause → PLAY, PLAYING
    - stop → STOP, IDLE
    - record → RECORD, RECORDING
  - RECORDING:
    - play_pause → PAUSE, REC_PAUSED
    - stop → STOP, IDLE
  - REC_PAUSED:
    - play_pause → PLAY, PLAYING
    - stop → STOP, IDLE
    - record → RECORD, RECORDING
  - A press with no listed transition is ignored and emits no code.
- Simultaneous transport presses: priority stop > record > play_pause. Only the winner is acted on.
- Hold window:
  - When a code is issued, the hold counter loads CODE_HOLD and o_event[15:12] shows the code until the counter reaches 0. It then returns to NONE.
  - Transport presses arriving while the counter is non-zero are dropped.
  - i_stop_signal is ignored while the counter is non-zero. This masks the core's stale flag during its length read.
- Speed:
  - Register resets to 1.
  - speed_up increments and saturates at 8; speed_down decrements and saturates at 1.
  - Both pressed in the same cycle: no change.
  - Speed keys are accepted in every state and during hold windows.
- Mode/interpol: the switches are 2-FF synchronized, not debounced, and mapped each cycle (mode 3 → 0).

## Timing
- Reset values:
  - o_event = 16'h0040 (code NONE, mode 0, speed 1, interpol 0)
  - o_state = IDLE
  - o_speed = 1
  - hold counter = 0
  - debounced levels = 1 (released)
- Reset is asynchronous and can occur mid-operation. Asserting i_rst_n=0 during a hold window clears the code immediately.
- Latency: raw key low from cycle 0 and held stable → press pulse at cycle DEBOUNCE_CYCLES+3, o_event code and o_state update at cycle DEBOUNCE_CYCLES+4.
- Speed change appears on o_event[9:6] at the same cycle as a transport code would.
- Switch changes reach o_event 3 cycles after the edge.
- Auto-stop: i_stop_signal sampled high in PLAYING with counter 0 at cycle k → STOP on o_event at k+1, o_state=IDLE at k+1.
- All outputs are registered.

## Structure
- Package recorder_pkg:
  - command code constants (REC_PLAY, REC_PAUSE, REC_STOP, REC_RECORD)
  - mode constants (REC_NORMAL, REC_SLOW, REC_FAST)
  - shadow-state enum
  - event field bit positions
  - This package is shared with the audio core.
- Sub-module key_debounce (synchronizer + debounce + press pulse), parameter DEBOUNCE_CYCLES, instantiated five times.

## Test plan
- Run the bench with DEBOUNCE_CYCLES=4, CODE_HOLD=4.
- Reset, then press play_pause → o_event[15:12]=1 for exactly 4 cycles starting at cycle 8, o_state=PLAYING, then code 0.
- PLAYING, press play_pause then play_pause again (after window) → codes 2 then 1; states PLAY_PAUSED then PLAYING.
- Bounce: key toggles every 2 cycles for 20 cycles, then stays low → exactly one PLAY code.
- Stop and record pressed in the same cycle from PLAY_PAUSED → single code 3, o_state=IDLE.
- PLAYING:
  - i_stop_signal=1 during the hold window → ignored.
  - i_stop_signal=1 after the window → code 3 next cycle, IDLE.
- Speed:
  - speed_up ×10 → o_speed=8 and o_event[9:6]=8.
  - speed_down ×10 → 1.
  - i_sw_mode=3 → o_event[11:10]=0.
